// File: rtl/pipe_hazard_sched.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_sched
// Description : Hazard and control scheduler for a short in-order pipeline.
//               Tracks outstanding register writes with a small per-register
//               pending counter (a scoreboard), raises data and structural
//               stalls for the decode stage, squashes wrong-path work on a
//               taken branch, and sequences external interrupts by draining
//               all outstanding writes before acknowledging.
//
// Configuration macro:
//   PIPE_HAZARD_FWD_EN  defined   -> full forwarding assumed; only a
//                                    load-use pair stalls (1-cycle tracker)
//                       undefined -> any source with a pending write stalls
//                                    until that write retires
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_id_valid                decode stage holds a valid instruction
//   i_id_ra / i_id_rb         decode source register indices
//   i_id_use_a / i_id_use_b   the matching source is really read
//   i_id_wr_en / i_id_rd      decode instruction writes register i_id_rd
//   i_id_is_load              decode instruction is a memory load
//   i_ex_br_taken             execute resolved a taken branch / jump
//   i_wb_wr_en / i_wb_rd      register write retiring this cycle
//   i_int_req                 level-sensitive interrupt request
//   o_stall_if / o_stall_id   hold PC and the IF/ID register
//   o_flush_id / o_flush_ex   insert a bubble into ID/EX and EX/MEM
//   o_int_ack                 one-cycle interrupt acknowledge
//   o_sb_empty                no register write pending
//
// Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_id_valid,
  input  logic [1:0] i_id_ra,
  input  logic [1:0] i_id_rb,
  input  logic       i_id_use_a,
  input  logic       i_id_use_b,
  input  logic       i_id_wr_en,
  input  logic [1:0] i_id_rd,
  input  logic       i_id_is_load,
  input  logic       i_ex_br_taken,
  input  logic       i_wb_wr_en,
  input  logic [1:0] i_wb_rd,
  input  logic       i_int_req,
  output logic       o_stall_if,
  output logic       o_stall_id,
  output logic       o_flush_id,
  output logic       o_flush_ex,
  output logic       o_int_ack,
  output logic       o_sb_empty
);

  localparam int    c_NREG    = 4;
  localparam logic [1:0] c_CNT_MAX = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  state_t     r_state;
  logic [1:0] r_cnt [c_NREG];

  logic [c_NREG-1:0] w_ret_hit;   // retire targets register g this cycle
  logic [c_NREG-1:0] w_iss_hit;   // issue targets register g this cycle
  logic [c_NREG-1:0] w_busy;      // reading register g now would be unsafe
  logic              w_hazard;
  logic              w_struct;
  logic              w_run_stall;
  logic              w_issue;

  // --------------------------------------------------------------------------
  // Per-register hazard condition
  // --------------------------------------------------------------------------
`ifdef PIPE_HAZARD_FWD_EN
  // Only a load result cannot be forwarded in time to the next instruction,
  // so remember the load issued last cycle (if any) and its destination.
  logic       r_ld_valid;
  logic [1:0] r_ld_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_valid <= 1'b0;
      r_ld_rd    <= 2'd0;
    end else begin
      r_ld_valid <= w_issue & i_id_is_load;
      r_ld_rd    <= i_id_rd;
    end
  end

  for (genvar g = 0; g < c_NREG; g++) begin : g_busy_fwd
    assign w_busy[g] = r_ld_valid & (r_ld_rd == 2'(g));
  end
`else
  // Without forwarding the source is busy while any write to it is still
  // outstanding. A write retiring this very cycle is visible to the reader
  // (write-through register file), so a lone pending write that is retiring
  // now no longer blocks: the stall drops in the retire cycle itself.
  logic w_unused_is_load;
  assign w_unused_is_load = i_id_is_load;

  for (genvar g = 0; g < c_NREG; g++) begin : g_busy_cnt
    assign w_busy[g] = (r_cnt[g] > {1'b0, w_ret_hit[g]});
  end
`endif

  for (genvar g = 0; g < c_NREG; g++) begin : g_hit
    assign w_ret_hit[g] = i_wb_wr_en & (i_wb_rd == 2'(g));
    assign w_iss_hit[g] = w_issue    & (i_id_rd == 2'(g));
  end

  assign w_hazard = i_id_valid &
                    ((i_id_use_a & w_busy[i_id_ra]) |
                     (i_id_use_b & w_busy[i_id_rb]));

  // A destination already carrying the maximum number of outstanding writes
  // cannot accept another one.
  assign w_struct = i_id_valid & i_id_wr_en & (r_cnt[i_id_rd] == c_CNT_MAX);

  assign w_run_stall = w_hazard | w_struct;

  assign o_sb_empty = (r_cnt[0] == 2'd0) & (r_cnt[1] == 2'd0) &
                      (r_cnt[2] == 2'd0) & (r_cnt[3] == 2'd0);

  // --------------------------------------------------------------------------
  // Output decode (combinational, zero latency from decode inputs)
  // --------------------------------------------------------------------------
  always_comb begin
    o_stall_if = 1'b0;
    o_stall_id = 1'b0;
    o_flush_id = 1'b0;
    o_flush_ex = 1'b0;
    o_int_ack  = 1'b0;
    case (r_state)
      ST_RUN: begin
        o_stall_if = w_run_stall;
        o_stall_id = w_run_stall;
        o_flush_id = w_run_stall;   // held decode slot becomes a bubble in EX
      end
      ST_FLUSH: begin
        o_flush_id = 1'b1;
        o_flush_ex = 1'b1;
      end
      ST_DRAIN: begin
        o_stall_if = 1'b1;
        o_stall_id = 1'b1;
        o_flush_id = 1'b1;
        o_flush_ex = i_ex_br_taken; // late branch still squashes its shadow
      end
      ST_ACK: begin
        o_flush_id = 1'b1;
        o_int_ack  = 1'b1;
      end
      default: begin
        o_stall_if = 1'b0;
      end
    endcase
  end

  assign w_issue = i_id_valid & i_id_wr_en & ~o_stall_id & ~o_flush_ex;

  // --------------------------------------------------------------------------
  // Pending-write counters
  // --------------------------------------------------------------------------
  // Issue and retire to the same register cancel. Counters saturate in both
  // directions: a retire at zero is ignored, and the rare issue that bypasses
  // the structural stall (ACK cycle) cannot wrap a full counter.
  always_ff @(posedge clk) begin
    for (int i = 0; i < c_NREG; i++) begin
      if (rst) begin
        r_cnt[i] <= 2'd0;
      end else if (w_iss_hit[i] && !w_ret_hit[i]) begin
        if (r_cnt[i] != c_CNT_MAX) begin
          r_cnt[i] <= r_cnt[i] + 2'd1;
        end
      end else if (w_ret_hit[i] && !w_iss_hit[i]) begin
        if (r_cnt[i] != 2'd0) begin
          r_cnt[i] <= r_cnt[i] - 2'd1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  // A taken branch wins over an interrupt; a still-asserted request is then
  // picked up once the FSM is back in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_ex_br_taken) begin
            r_state <= ST_FLUSH;
          end else if (i_int_req) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_FLUSH: r_state <= ST_RUN;
        ST_DRAIN: begin
          if (o_sb_empty) begin
            r_state <= ST_ACK;
          end
        end
        ST_ACK:   r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_sched
// Description : Self-checking bench for pipe_hazard_sched. A stimulus process
//               drives directed scenarios followed by random traffic; for
//               every cycle a behavioural model predicts all six outputs and
//               queues them. A monitor process compares the DUT outputs
//               against the queue on the falling edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       id_valid = 1'b0, id_use_a = 1'b0, id_use_b = 1'b0;
  logic       id_wr_en = 1'b0, id_is_load = 1'b0;
  logic [1:0] id_ra = 2'd0, id_rb = 2'd0, id_rd = 2'd0, wb_rd = 2'd0;
  logic       ex_br_taken = 1'b0, wb_wr_en = 1'b0, int_req = 1'b0;
  logic       stall_if, stall_id, flush_id, flush_ex, int_ack, sb_empty;

  pipe_hazard_sched dut (
    .clk          (clk),
    .rst          (rst),
    .i_id_valid   (id_valid),
    .i_id_ra      (id_ra),
    .i_id_rb      (id_rb),
    .i_id_use_a   (id_use_a),
    .i_id_use_b   (id_use_b),
    .i_id_wr_en   (id_wr_en),
    .i_id_rd      (id_rd),
    .i_id_is_load (id_is_load),
    .i_ex_br_taken(ex_br_taken),
    .i_wb_wr_en   (wb_wr_en),
    .i_wb_rd      (wb_rd),
    .i_int_req    (int_req),
    .o_stall_if   (stall_if),
    .o_stall_id   (stall_id),
    .o_flush_id   (flush_id),
    .o_flush_ex   (flush_ex),
    .o_int_ack    (int_ack),
    .o_sb_empty   (sb_empty)
  );

  typedef struct {
    bit       rst;
    bit       valid;
    bit [1:0] ra, rb;
    bit       use_a, use_b, wr_en;
    bit [1:0] rd;
    bit       is_load, br, wb_en;
    bit [1:0] wb_rd;
    bit       intr;
  } stim_t;

  // Scoreboard: expected {stall_if, stall_id, flush_id, flush_ex, int_ack, sb_empty}
  logic [5:0] exp_q [$];
  string      tag_q [$];
  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  string      phase  = "reset";

  // Behavioural model: outstanding writes per register and a control mode.
  localparam int M_RUN = 0, M_FLUSH = 1, M_DRAIN = 2, M_ACK = 3;
  int m_cnt [4];
  int m_mode     = M_RUN;
  bit m_known    = 1'b0;
  bit m_ld_valid = 1'b0;
  int m_ld_rd    = 0;

  function automatic bit src_busy(int r, stim_t s);
`ifdef PIPE_HAZARD_FWD_EN
    return m_ld_valid && (m_ld_rd == r);
`else
    int p = m_cnt[r];
    if (s.wb_en && s.wb_rd == r && p > 0) p--;
    return p > 0;
`endif
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic step(input stim_t s);
    bit haz, strl, sid, fid, fex, ack, empty, issue;
    @(posedge clk);
    #1;
    cyc++;
    rst = s.rst; id_valid = s.valid; id_ra = s.ra; id_rb = s.rb;
    id_use_a = s.use_a; id_use_b = s.use_b; id_wr_en = s.wr_en; id_rd = s.rd;
    id_is_load = s.is_load; ex_br_taken = s.br; wb_wr_en = s.wb_en;
    wb_rd = s.wb_rd; int_req = s.intr;

    haz   = s.valid && ((s.use_a && src_busy(s.ra, s)) || (s.use_b && src_busy(s.rb, s)));
    strl  = s.valid && s.wr_en && (m_cnt[s.rd] == 3);
    empty = (m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3]) == 0;
    sid = 0; fid = 0; fex = 0; ack = 0;
    case (m_mode)
      M_RUN:   begin sid = haz || strl; fid = sid; end
      M_FLUSH: begin fid = 1; fex = 1; end
      M_DRAIN: begin sid = 1; fid = 1; fex = s.br; end
      default: begin fid = 1; ack = 1; end
    endcase
    if (m_known) begin
      exp_q.push_back({sid, sid, fid, fex, ack, empty});
      tag_q.push_back($sformatf("%s/cyc%0d", phase, cyc));
    end

    issue = s.valid && s.wr_en && !sid && !fex;
    if (s.rst) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_mode = M_RUN; m_ld_valid = 0; m_ld_rd = 0; m_known = 1;
    end else begin
      if (!(issue && s.wb_en && s.rd == s.wb_rd)) begin
        if (issue && m_cnt[s.rd] < 3) m_cnt[s.rd]++;
        if (s.wb_en && m_cnt[s.wb_rd] > 0) m_cnt[s.wb_rd]--;
      end
      m_ld_valid = issue && s.is_load;
      m_ld_rd    = s.rd;
      case (m_mode)
        M_RUN:   m_mode = s.br ? M_FLUSH : (s.intr ? M_DRAIN : M_RUN);
        M_FLUSH: m_mode = M_RUN;
        M_DRAIN: m_mode = empty ? M_ACK : M_DRAIN;
        default: m_mode = M_RUN;
      endcase
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set.
  initial begin
    logic [5:0] e, a;
    string      t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = {stall_if, stall_id, flush_id, flush_ex, int_ack, sb_empty};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs %s {sif,sid,fid,fex,ack,sbe} actual=%b required=%b", t, a, e);
        end
      end
    end
  end

  initial begin
    stim_t s;
    int    hold;
    // Reset
    s = idle(); s.rst = 1; step(s); step(s);
    phase = "post_reset"; s = idle(); step(s);

    // Issue to r2, observe pending, retire, observe empty
    phase = "issue_retire";
    s = idle(); s.valid = 1; s.wr_en = 1; s.rd = 2; step(s);
    s = idle(); step(s);
    s = idle(); s.wb_en = 1; s.wb_rd = 2; step(s);
    s = idle(); step(s);

    // Load producer followed by a reader, then retire
    phase = "load_use";
    s = idle(); s.valid = 1; s.wr_en = 1; s.is_load = 1; s.rd = 1; step(s);
    s = idle(); s.valid = 1; s.use_a = 1; s.ra = 1; step(s); step(s); step(s);
    s.wb_en = 1; s.wb_rd = 1; step(s);
    s = idle(); step(s);

    // Non-load producer followed by a reader on rb
    phase = "alu_use";
    s = idle(); s.valid = 1; s.wr_en = 1; s.rd = 3; step(s);
    s = idle(); s.valid = 1; s.use_b = 1; s.rb = 3; step(s); step(s);
    s.wb_en = 1; s.wb_rd = 3; step(s);
    s = idle(); step(s);

    // Saturation of r0, cancel of simultaneous issue/retire, no wrap at zero
    phase = "saturate";
    s = idle(); s.valid = 1; s.wr_en = 1; s.rd = 0; step(s); step(s); step(s);
    step(s); step(s);                                   // fourth write held
    s = idle(); s.wb_en = 1; s.wb_rd = 0; step(s);      // cnt 3 -> 2
    s = idle(); s.valid = 1; s.wr_en = 1; s.rd = 0; s.wb_en = 1; s.wb_rd = 0; step(s);
    s = idle(); s.wb_en = 1; s.wb_rd = 0; step(s); step(s);
    step(s);                                            // retire at zero
    s = idle(); step(s);

    // Interrupt with two pending writes, late branch during drain
    phase = "interrupt";
    s = idle(); s.valid = 1; s.wr_en = 1; s.rd = 1; step(s);
    s.rd = 2; step(s);
    s = idle(); s.intr = 1; step(s); step(s);
    s.br = 1; step(s);
    s.br = 0; step(s);
    s.wb_en = 1; s.wb_rd = 1; step(s);
    s.wb_rd = 2; step(s);
    s = idle(); s.intr = 1; step(s);
    s = idle(); step(s); step(s);

    // Branch and interrupt together
    phase = "br_and_int";
    s = idle(); s.br = 1; s.intr = 1; step(s);
    s.br = 0; step(s); step(s); step(s);
    s = idle(); step(s); step(s);

    // Reset in the middle of a drain
    phase = "drain_reset";
    s = idle(); s.valid = 1; s.wr_en = 1; s.rd = 3; step(s);
    s = idle(); s.intr = 1; step(s); step(s); step(s);
    s = idle(); s.rst = 1; step(s);
    s = idle(); step(s); step(s); step(s);

    // Random traffic
    phase = "random";
    hold = 0;
    for (int n = 0; n < 4000; n++) begin
      s = idle();
      s.rst     = ($urandom_range(0, 299) == 0);
      s.valid   = ($urandom_range(0, 3) != 0);
      s.ra      = 2'($urandom_range(0, 3));
      s.rb      = 2'($urandom_range(0, 3));
      s.use_a   = $urandom_range(0, 1);
      s.use_b   = $urandom_range(0, 1);
      s.wr_en   = $urandom_range(0, 1);
      s.rd      = 2'($urandom_range(0, 3));
      s.is_load = ($urandom_range(0, 2) == 0);
      s.br      = ($urandom_range(0, 15) == 0);
      s.wb_en   = ($urandom_range(0, 2) == 0);
      s.wb_rd   = 2'($urandom_range(0, 3));
      if (hold == 0 && $urandom_range(0, 39) == 0) hold = $urandom_range(1, 12);
      s.intr = (hold != 0);
      if (hold != 0) hold--;
      step(s);
    end

    s = idle(); step(s);
    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue actual=%0d required=0 entries", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_sched.md
PIPE_HAZARD_SCHED -- requirements
Module: pipe_hazard_sched

Interface
REQ-001 SHALL provide clk input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL provide rst input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL provide id_valid input, 1 bit: the decode stage holds a valid instruction.
REQ-004 SHALL provide id_ra and id_rb inputs, 2 bits each: decode source register indices.
REQ-005 SHALL provide id_use_a and id_use_b inputs, 1 bit each: the matching source is actually read.
REQ-006 SHALL provide id_wr_en input (1 bit) and id_rd input (2 bits): decode writes destination id_rd.
REQ-007 SHALL provide id_is_load input, 1 bit: the decode instruction is a memory load.
REQ-008 SHALL provide ex_br_taken input, 1 bit: the execute stage resolved a taken branch or jump.
REQ-009 SHALL provide wb_wr_en input (1 bit) and wb_rd input (2 bits): register write retiring this cycle.
REQ-010 SHALL provide int_req input, 1 bit: level-sensitive external interrupt request.
REQ-011 SHALL provide stall_if and stall_id outputs, 1 bit each: hold PC and the IF/ID register.
REQ-012 SHALL provide flush_id and flush_ex outputs, 1 bit each: insert a bubble into ID/EX and EX/MEM.
REQ-013 SHALL provide int_ack output (1 bit): one-cycle interrupt acknowledge. SHALL provide sb_empty output (1 bit): no register write pending.

Function
REQ-014 SHALL keep one 2-bit pending counter per register (4 total).
REQ-015 An issue (id_valid & id_wr_en & ~stall_id & ~flush_ex) SHALL increment cnt[id_rd]. A retire (wb_wr_en) SHALL decrement cnt[wb_rd]. An issue and a retire on the same register in the same cycle SHALL leave the counter unchanged.
REQ-016 A retire to a counter already at 0 SHALL leave it at 0 (no wrap).
REQ-017 A hazard SHALL be raised when id_valid, and either id_use_a with an active hazard on id_ra or id_use_b with an active hazard on id_rb. The per-register hazard condition depends on FWD_EN (REQ-029).
REQ-018 A structural stall SHALL be raised when id_valid & id_wr_en & cnt[id_rd]==3.
REQ-019 In state RUN, stall_if = stall_id = hazard | structural stall; flush_id SHALL equal the same value, so a bubble enters EX. All three SHALL be combinational, with zero-cycle latency.
REQ-020 FSM states SHALL be RUN, FLUSH, DRAIN and ACK.
REQ-021 RUN->FLUSH SHALL occur on ex_br_taken. FLUSH SHALL assert flush_id and flush_ex for exactly 1 cycle, with stalls deasserted, then return to RUN.
REQ-022 RUN->DRAIN SHALL occur on int_req when ex_br_taken is low. ex_br_taken SHALL take priority when both are asserted; the interrupt is taken after FLUSH if int_req is still high.
REQ-023 DRAIN SHALL hold stall_if=stall_id=flush_id=1 until sb_empty, then go to ACK.
REQ-024 ACK SHALL assert int_ack and flush_id for 1 cycle, then return to RUN.
REQ-025 sb_empty SHALL be 1 iff all counters are 0.
REQ-026 ex_br_taken arriving in DRAIN SHALL still assert flush_ex that cycle, and the FSM SHALL remain in DRAIN.

Reset
REQ-027 On rst high at a clock edge, all counters, the load tracker and the FSM SHALL clear (FSM to RUN). This includes mid-DRAIN and mid-FLUSH.
REQ-028 Post-reset outputs SHALL be: stall_if=stall_id=flush_id=flush_ex=int_ack=0 and sb_empty=1.

Configuration
REQ-029 Macro PIPE_HAZARD_FWD_EN SHALL select the hazard rule:
- Defined: only a load-use hazard stalls. A 1-bit tracker records the last issued load and its rd for one cycle; a hazard exists when it matches a used source.
- Undefined: any source whose cnt is nonzero stalls until retire.

Verification
REQ-030 Reset scenario: after reset, issue rd=2 with no retire -> cnt[2]=1 and sb_empty=0. Then retire rd=2 -> sb_empty=1.
REQ-031 Load-use scenario, FWD_EN defined: load rd=1, next instr reads ra=1 -> stall_id=1 for exactly 1 cycle. A non-load producer -> no stall.
REQ-032 Dependency scenario, FWD_EN undefined: issue rd=3, dependent reads rb=3 -> stall held until wb_rd=3 retires, released in the same cycle.
REQ-033 Saturation scenario: three issues to rd=0 with no retire -> the fourth write to rd=0 stalls. Simultaneous issue and retire on rd=0 -> cnt unchanged.
REQ-034 Interrupt scenario: int_req with 2 pending writes -> DRAIN with stalls until both retire, then int_ack=1 for 1 cycle. ex_br_taken and int_req in the same cycle -> FLUSH first, then DRAIN.
REQ-035 Mid-DRAIN reset scenario: rst asserted during DRAIN -> next cycle is RUN, all outputs at reset values, and no int_ack is asserted.
